// File: rtl/mux_sweep_checker_if.sv
// Stimulus/response bus between the sweep checker and the mux under test.
// The checker side drives the vector and samples the mux output.
interface mux_sweep_checker_if #(
  parameter int SEL_W = 1
) ();
  localparam int N = 2**SEL_W;

  logic [N-1:0]     stim_data;
  logic [SEL_W-1:0] stim_sel;
  logic             stim_valid;
  logic             dut_z;

  modport master (output stim_data, output stim_sel, output stim_valid, input dut_z);
  modport slave  (input stim_data, input stim_sel, input stim_valid, output dut_z);
endinterface

// File: rtl/mux_sweep_checker.sv
// Exhaustive sweep engine: drives every {sel,data} vector to an external N:1 mux
// and scores its output against a golden bit delayed LAT cycles.
module mux_sweep_checker #(
  parameter int  SEL_W = 1,
  parameter int  LAT   = 1,
  localparam int N     = 2**SEL_W,
  localparam int TV_W  = SEL_W + N,
  localparam int CNT_W = TV_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop_on_fail,
  mux_sweep_checker_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pass_count,
  output logic [CNT_W-1:0]    fail_count,
  output logic [TV_W-1:0]     first_fail_vec,
  output logic                first_fail_valid
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [TV_W-1:0]   cnt_q;
  logic [2:0]        dcnt_q;
  logic              stop_q;
  logic [CNT_W-1:0]  pass_q, fail_q;
  logic [TV_W-1:0]   ffv_q;
  logic              ffvld_q;

  logic              start_acc, last_vec, drain_end, abort;
  logic              exp_live, cmp_vld, cmp_exp, cmp_match;
  logic [TV_W-1:0]   vec_live, cmp_vec;

  assign start_acc = start && (state_q == IDLE || state_q == DONE);
  assign last_vec  = (cnt_q == {TV_W{1'b1}});
  assign drain_end = (dcnt_q == 3'(LAT - 1));
  assign exp_live  = bus.stim_data[bus.stim_sel];
  assign vec_live  = {bus.stim_sel, bus.stim_data};
  // Case equality so an X or Z from the mux scores as a mismatch.
  assign cmp_match = (bus.dut_z === cmp_exp);
  assign abort     = busy && cmp_vld && !cmp_match && stop_q;

  generate
    if (LAT == 0) begin : g_comb
      assign cmp_vld = bus.stim_valid;
      assign cmp_exp = exp_live;
      assign cmp_vec = vec_live;
    end else begin : g_pipe
      logic [LAT-1:0]  vld_q, exp_q;
      logic [TV_W-1:0] vec_q [LAT];

      always_ff @(posedge clk) begin
        if (rst || start_acc || abort) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= bus.stim_valid;
          for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        exp_q[0] <= exp_live;
        vec_q[0] <= vec_live;
        for (int i = 1; i < LAT; i++) begin
          exp_q[i] <= exp_q[i-1];
          vec_q[i] <= vec_q[i-1];
        end
      end

      assign cmp_vld = vld_q[LAT-1];
      assign cmp_exp = exp_q[LAT-1];
      assign cmp_vec = vec_q[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN: begin
        if (abort)         state_d = DONE;
        else if (last_vec) state_d = (LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: if (abort || drain_end) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    bus.stim_valid = 1'b0;
    bus.stim_sel   = '0;
    bus.stim_data  = '0;
    case (state_q)
      RUN: begin
        busy           = 1'b1;
        bus.stim_valid = 1'b1;
        bus.stim_sel   = cnt_q[TV_W-1:N];
        bus.stim_data  = cnt_q[N-1:0];
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      dcnt_q  <= '0;
      stop_q  <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
      ffv_q   <= '0;
      ffvld_q <= 1'b0;
    end else if (start_acc) begin
      cnt_q   <= '0;
      dcnt_q  <= '0;
      stop_q  <= stop_on_fail;
      pass_q  <= '0;
      fail_q  <= '0;
      ffv_q   <= '0;
      ffvld_q <= 1'b0;
    end else begin
      if (state_q == RUN) cnt_q <= cnt_q + 1'b1;
      dcnt_q <= (state_q == DRAIN) ? dcnt_q + 3'd1 : 3'd0;
      if (busy && cmp_vld) begin
        if (cmp_match) begin
          pass_q <= pass_q + 1'b1;
        end else begin
          fail_q <= fail_q + 1'b1;
          if (!ffvld_q) begin
            ffv_q   <= cmp_vec;
            ffvld_q <= 1'b1;
          end
        end
      end
    end
  end

  assign pass_count       = pass_q;
  assign fail_count       = fail_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvld_q;
endmodule

// File: tb/tb_mux_sweep_checker.sv
// Bench for mux_sweep_checker: three checker configurations, each beside a behavioural
// mux whose wrong answers come from a per-vector flip mask or a stuck-at-0 mode.
module tb_mux_sweep_checker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  localparam int G_DONE = 0, G_BUSY = 1, G_VALID = 2, G_PASS = 3, G_FAIL = 4,
                 G_FFV = 5, G_FFVLD = 6, G_VEC = 7;

  logic start0, start1, start2, stop0, stop1, stop2;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic [3:0] pass0, fail0;
  logic [6:0] pass1, fail1, pass2, fail2;
  logic [2:0] ffv0;
  logic [5:0] ffv1, ffv2;
  logic ffvld0, ffvld1, ffvld2;

  mux_sweep_checker_if #(.SEL_W(1)) if0 ();
  mux_sweep_checker_if #(.SEL_W(2)) if1 ();
  mux_sweep_checker_if #(.SEL_W(2)) if2 ();

  mux_sweep_checker #(.SEL_W(1), .LAT(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .stop_on_fail(stop0), .bus(if0),
    .busy(busy0), .done(done0), .pass_count(pass0), .fail_count(fail0),
    .first_fail_vec(ffv0), .first_fail_valid(ffvld0));
  mux_sweep_checker #(.SEL_W(2), .LAT(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .stop_on_fail(stop1), .bus(if1),
    .busy(busy1), .done(done1), .pass_count(pass1), .fail_count(fail1),
    .first_fail_vec(ffv1), .first_fail_valid(ffvld1));
  mux_sweep_checker #(.SEL_W(2), .LAT(0)) u2 (
    .clk(clk), .rst(rst), .start(start2), .stop_on_fail(stop2), .bus(if2),
    .busy(busy2), .done(done2), .pass_count(pass2), .fail_count(fail2),
    .first_fail_vec(ffv2), .first_fail_valid(ffvld2));

  // Muxes under test: 1-cycle, 3-cycle and combinational.
  logic [7:0]  mask0;
  logic [63:0] mask1, mask2;
  logic        sa0;
  logic        z0_q;
  logic [2:0]  z1_sr;
  always @(posedge clk)
    z0_q <= sa0 ? 1'b0 : (if0.stim_data[if0.stim_sel] ^ mask0[{if0.stim_sel, if0.stim_data}]);
  always @(posedge clk)
    z1_sr <= {z1_sr[1:0], if1.stim_data[if1.stim_sel] ^ mask1[{if1.stim_sel, if1.stim_data}]};
  assign if0.dut_z = z0_q;
  assign if1.dut_z = z1_sr[2];
  assign if2.dut_z = if2.stim_data[if2.stim_sel] ^ mask2[{if2.stim_sel, if2.stim_data}];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] get(input int id, input int what);
    logic [63:0] r;
    r = '0;
    case (id)
      0: case (what)
        G_DONE: r = 64'(done0);          G_BUSY:  r = 64'(busy0);
        G_VALID: r = 64'(if0.stim_valid); G_PASS:  r = 64'(pass0);
        G_FAIL: r = 64'(fail0);          G_FFV:   r = 64'(ffv0);
        G_FFVLD: r = 64'(ffvld0);        default: r = 64'({if0.stim_sel, if0.stim_data});
      endcase
      1: case (what)
        G_DONE: r = 64'(done1);          G_BUSY:  r = 64'(busy1);
        G_VALID: r = 64'(if1.stim_valid); G_PASS:  r = 64'(pass1);
        G_FAIL: r = 64'(fail1);          G_FFV:   r = 64'(ffv1);
        G_FFVLD: r = 64'(ffvld1);        default: r = 64'({if1.stim_sel, if1.stim_data});
      endcase
      default: case (what)
        G_DONE: r = 64'(done2);          G_BUSY:  r = 64'(busy2);
        G_VALID: r = 64'(if2.stim_valid); G_PASS:  r = 64'(pass2);
        G_FAIL: r = 64'(fail2);          G_FFV:   r = 64'(ffv2);
        G_FFVLD: r = 64'(ffvld2);        default: r = 64'({if2.stim_sel, if2.stim_data});
      endcase
    endcase
    return r;
  endfunction

  task automatic set_start(input int id, input logic v);
    case (id)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic set_stop(input int id, input logic v);
    case (id)
      0: stop0 = v;
      1: stop1 = v;
      default: stop2 = v;
    endcase
  endtask

  // Vectors a stuck-at-0 output gets wrong on the 2:1 checker: those whose selected bit is 1.
  function automatic logic [63:0] sa0_bad();
    logic [63:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) b[k] = 1'(((k & 3) >> (k >> 2)) & 1);
    return b;
  endfunction

  task automatic check_reset(input int id, input string tag);
    chk({tag, " busy"},   get(id, G_BUSY),  0);
    chk({tag, " done"},   get(id, G_DONE),  0);
    chk({tag, " valid"},  get(id, G_VALID), 0);
    chk({tag, " vec"},    get(id, G_VEC),   0);
    chk({tag, " pass"},   get(id, G_PASS),  0);
    chk({tag, " fail"},   get(id, G_FAIL),  0);
    chk({tag, " ffv"},    get(id, G_FFV),   0);
    chk({tag, " ffvld"},  get(id, G_FFVLD), 0);
  endtask

  // One full sweep; bad[k]=1 means the mux answers vector k wrongly.
  task automatic run_sweep(input int id, input logic stop, input logic [63:0] bad,
                           input int mid_start, input string tag);
    int nvec, lat, first, nfail, e_done, e_pass, e_fail, e_vcnt, vcnt, order_err, n;
    logic found;
    nvec  = (id == 0) ? 8 : 64;
    lat   = (id == 0) ? 1 : ((id == 1) ? 3 : 0);
    first = -1;
    nfail = 0;
    for (int k = 0; k < nvec; k++)
      if (bad[k]) begin
        nfail++;
        if (first < 0) first = k;
      end
    if (stop && first >= 0) begin
      e_done = first + 1 + lat;
      e_pass = first;
      e_fail = 1;
      e_vcnt = (first + 1 + lat < nvec) ? first + 1 + lat : nvec;
    end else begin
      e_done = nvec + lat;
      e_pass = nvec - nfail;
      e_fail = nfail;
      e_vcnt = nvec;
    end

    @(negedge clk);
    set_start(id, 1'b1);
    set_stop(id, stop);
    @(posedge clk);
    #1;
    set_start(id, 1'b0);
    chk({tag, " clr_pass"},  get(id, G_PASS),  0);
    chk({tag, " clr_fail"},  get(id, G_FAIL),  0);
    chk({tag, " clr_ffvld"}, get(id, G_FFVLD), 0);
    chk({tag, " run_busy"},  get(id, G_BUSY),  1);

    vcnt = 0; order_err = 0; found = 1'b0; n = 0;
    while (!found && n <= e_done + 20) begin
      if (get(id, G_VALID) == 64'd1) begin
        vcnt++;
        if (get(id, G_VEC) != 64'(n)) order_err++;
      end else if (get(id, G_VEC) != 64'd0) begin
        order_err++;
      end
      n++;
      @(posedge clk);
      #1;
      set_start(id, n == mid_start);
      if (n == mid_start) set_stop(id, ~stop);
      found = (get(id, G_DONE) == 64'd1);
    end
    set_start(id, 1'b0);

    chk({tag, " done_seen"},  64'(found), 1);
    chk({tag, " done_cycle"}, 64'(n), 64'(e_done));
    chk({tag, " pass"},       get(id, G_PASS), 64'(e_pass));
    chk({tag, " fail"},       get(id, G_FAIL), 64'(e_fail));
    chk({tag, " ffvld"},      get(id, G_FFVLD), 64'(first >= 0));
    chk({tag, " ffv"},        get(id, G_FFV), (first >= 0) ? 64'(first) : 64'd0);
    chk({tag, " vec_cycles"}, 64'(vcnt), 64'(e_vcnt));
    chk({tag, " vec_order"},  64'(order_err), 0);
    chk({tag, " end_busy"},   get(id, G_BUSY), 0);
    @(posedge clk);
    #1;
    chk({tag, " done_hold"},  get(id, G_DONE), 1);
    chk({tag, " idle_valid"}, get(id, G_VALID), 0);
    chk({tag, " pass_hold"},  get(id, G_PASS), 64'(e_pass));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    logic [63:0] bad, sab;
    logic        stp;
    int          id, e_pre;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    stop0 = 1'b0;  stop1 = 1'b0;  stop2 = 1'b0;
    mask0 = '0; mask1 = '0; mask2 = '0; sa0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset(0, "reset_u0");
    check_reset(1, "reset_u1");
    @(negedge clk);
    rst = 1'b0;

    sab = sa0_bad();
    run_sweep(0, 1'b0, '0, 0, "u0_ok");
    sa0 = 1'b1;
    run_sweep(0, 1'b0, sab, 0, "u0_sa0");
    run_sweep(0, 1'b1, sab, 0, "u0_sa0_stop");
    sa0 = 1'b0;
    run_sweep(0, 1'b0, '0, 3, "u0_restart_midstart");
    run_sweep(1, 1'b0, '0, 0, "u1_ok");
    run_sweep(2, 1'b0, '0, 0, "u2_ok");

    for (int r = 0; r < 9; r++) begin
      id  = r % 3;
      bad = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      stp = 1'($urandom_range(0, 1));
      case (id)
        0: begin bad = bad & 64'hFF; mask0 = bad[7:0]; end
        1: mask1 = bad;
        default: mask2 = bad;
      endcase
      run_sweep(id, stp, bad, (r == 4) ? 5 : 0, $sformatf("rand%0d_u%0d", r, id));
    end
    mask0 = '0; mask1 = '0; mask2 = '0;

    // Reset in the middle of a failing sweep, with start raised alongside it.
    sa0 = 1'b1;
    @(negedge clk);
    start0 = 1'b1;
    stop0  = 1'b0;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    e_pre = 0;
    for (int k = 0; k <= 3; k++) if (sab[k]) e_pre++;
    chk("rst_pre_vec",  get(0, G_VEC), 5);
    chk("rst_pre_fail", get(0, G_FAIL), 64'(e_pre));
    @(negedge clk);
    rst    = 1'b1;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    check_reset(0, "rst_mid");
    @(negedge clk);
    rst    = 1'b0;
    start0 = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_start_ignored_busy", get(0, G_BUSY), 0);
    chk("rst_start_ignored_done", get(0, G_DONE), 0);
    sa0 = 1'b0;
    run_sweep(0, 1'b0, '0, 0, "u0_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_sweep_checker.md
# mux_sweep_checker

Self-checking exhaustive sweep engine for an N:1 one-bit multiplexer under test. It is the parametrised successor to the 3-input a/b/c mux check: it steps a counter through every {select, data} combination and drives each one to the external DUT. It compares the DUT output, returned after a configurable pipeline latency, against an internal golden model and reports pass/fail counts, the first failing vector and completion. It sits beside the DUT in lab benches and on-board self-test wrappers.

## Interface
Parameters:
- SEL_W, default 1: select width; N = 2**SEL_W data inputs. Legal range is 1..3.
- LAT, default 1: DUT latency in cycles from stimulus to dut_z. Legal range is 0..7.
- Derived, not overridable: TV_W = SEL_W + N (vector width); CNT_W = TV_W + 1.

Ports:
- clk, input, 1: the only clock; rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin a sweep. Sampled only in IDLE or DONE.
- stop_on_fail, input, 1: sampled with start and held for the whole sweep.
- stim_data, output, N: DUT data inputs; stim_data[i] is data input i.
- stim_sel, output, SEL_W: DUT select.
- stim_valid, output, 1: stim_data/stim_sel carry a live vector.
- dut_z, input, 1: DUT output.
- busy, output, 1: high in RUN or DRAIN.
- done, output, 1: high in DONE.
- pass_count, output, CNT_W: number of matching compares.
- fail_count, output, CNT_W: number of mismatching compares.
- first_fail_vec, output, TV_W: {sel, data} of the first mismatch.
- first_fail_valid, output, 1: first_fail_vec holds a captured mismatch.

## Operation
- States are IDLE, RUN, DRAIN and DONE. Reset enters IDLE.
- IDLE or DONE with start=1: clear counts, first_fail_*, the vector counter and the expect pipeline. Latch stop_on_fail and go to RUN.
- RUN:
  - Drive vector v = counter, with stim_sel = v[TV_W-1:N] and stim_data = v[N-1:0]; stim_valid=1.
  - Counter increments each cycle.
  - After vector 2**TV_W-1 is driven, go to DRAIN if LAT>0, otherwise go to DONE.
- DRAIN: stim_valid=0; wait LAT cycles, then go to DONE.
- DONE: done=1; counts and first_fail_* hold until start or rst.
- Golden model: expected = stim_data[stim_sel]. The expected bit and vector are delayed LAT stages in a valid-tagged shift pipeline.
- Compare, at each edge where the pipeline output is valid:
  - dut_z === expected increments pass_count. X or Z on dut_z counts as a fail.
  - Otherwise fail_count increments. If first_fail_valid=0, capture the vector and set first_fail_valid.
- stop_on_fail=1, first mismatch:
  - Count that mismatch.
  - Go directly to DONE on the same edge.
  - Discard in-flight pipeline entries (they are not counted) and drive no further vectors.
- start while busy is ignored. stop_on_fail changes mid-sweep are ignored.
- When stim_valid=0, stim_data and stim_sel are driven to 0.
- Counts cannot overflow: the maximum is 2**TV_W, which is below 2**CNT_W.

## Timing
- Reset values: busy=0, done=0, stim_valid=0, stim_data=0, stim_sel=0, pass_count=0, fail_count=0, first_fail_vec=0, first_fail_valid=0. The pipeline valid bits are cleared.
- rst asserted mid-sweep wins over everything. Outputs hold their reset values one cycle later; the block is in IDLE, and a start in the same cycle as rst is ignored.
- start sampled at edge E0:
  - Vector k is driven during the cycle after edge E0+k.
  - Its compare registers at edge E0+k+1+LAT.
- done rises at edge E0 + 2**TV_W + LAT. The final counts are visible in that same cycle. busy falls on the same edge.
- LAT=0: dut_z is sampled in the same cycle the vector is driven, so the DUT path is combinational.
- Restart from DONE: counts clear on the start edge, and vector 0 is driven in the next cycle.

## Test plan
- SEL_W=1, LAT=1, correct mux DUT, start pulse: done 9 cycles after start, pass_count=8, fail_count=0, first_fail_valid=0.
- SEL_W=1, LAT=1, dut_z stuck-at-0: pass_count=4, fail_count=4, first_fail_vec=3'b001, first_fail_valid=1.
- Same stuck-at-0 DUT with stop_on_fail=1: done at start+2+LAT edges, pass_count=1, fail_count=1, no stim_valid after vector 1.
- SEL_W=2, LAT=3, correct DUT modelled as a 3-stage delayed mux: pass_count=64, fail_count=0, done at start+67. Repeat with LAT=0 and a combinational mux: pass_count=64, done at start+64.
- rst asserted at RUN vector 5, and a start pulse mid-RUN: after rst all outputs return to reset values and the block is IDLE. The mid-run start is ignored, with counts unaffected and done timing unchanged.
- Restart from DONE after a failing sweep, with the DUT corrected: counts clear, then the final pass_count=8, fail_count=0, first_fail_valid=0.
